piso_serializer_8bit: RTL

- Parallel-in, serial-out shifter; the transmit-side counterpart of the team's 8-bit serial-in shift register.
- Accepts a parallel word through a valid/ready handshake and emits it one bit per enabled clock, LSB first.
- Bit order: a serial-in register that shifts right and enters new bits at the MSB ends up holding the original word after WIDTH shifts.
- Sits between a parallel data source and the serial-in shift register or link.

---
 rtl/piso_serializer_8bit.sv | 89 ++++++++
 1 files changed

// File: rtl/piso_serializer_8bit.sv
// Parallel-in, serial-out shifter: accepts a word on a valid/ready handshake and
// emits it LSB first, one bit per enabled clock, then pulses Done for one cycle.
module piso_serializer_8bit #(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                       Clk,
  input  logic                       RS,
  input  logic [WIDTH-1:0]           DIn,
  input  logic                       DValid,
  output logic                       DReady,
  input  logic                       En,
  output logic                       SOD,
  output logic                       SOV,
  output logic                       Busy,
  output logic                       Done,
  output logic [$clog2(WIDTH+1)-1:0] BitCnt
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sod_q, sod_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (DValid) begin
          shreg_d = DIn;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (En) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) state_d = StDone;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Output registers are loaded from the next state so they line up with it.
    sod_d  = (state_d == StShift) ? shreg_d[0] : IDLE_LEVEL;
    busy_d = (state_d == StShift);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge Clk or negedge RS) begin
    if (!RS) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      sod_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sod_q   <= sod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // SOV tracks En so a receiver samples SOD exactly on the edges that advance it.
  assign SOV    = (state_q == StShift) && En;
  assign DReady = (state_q == StIdle) && RS;
  assign SOD    = sod_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign BitCnt = cnt_q;

endmodule
